bpu_write_arbiter: RTL and testbench

BPU_WRITE_ARBITER -- requirements
Module: bpu_write_arbiter

---
 rtl/bpu_pkg.sv | 15 +
 rtl/bpu_upd_fifo.sv | 72 +++++++
 rtl/bpu_write_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_bpu_write_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared BPU definitions: table write kinds and the write-arbiter FSM states.
package bpu_pkg;

  typedef enum logic [1:0] {
    WR_ALLOC  = 2'b00,
    WR_UPDATE = 2'b01,
    WR_CLEAR  = 2'b10
  } wr_kind_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

endpackage : bpu_pkg

// File: rtl/bpu_upd_fifo.sv
// Update FIFO for resolved-branch writes waiting on the table write port.
// Ports:
//   clk_i, rst_i   clock, async active-high reset (pointers only)
//   flush_i        discard all contents (wins over push/pop)
//   push_i/data_i  enqueue (ignored when full)
//   pop_i          dequeue head (ignored when empty)
//   data_o         head entry, valid when empty_o=0
//   full_o/empty_o occupancy flags
module bpu_upd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : bpu_upd_fifo

// File: rtl/bpu_write_arbiter.sv
// Single write port arbiter for the BPU table: allocations from decode,
// queued updates from execute, and a full-table clear sequence on flush.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   stall_i                 blocks all table writes while high
//   flush_req_i             start/restart a full-table clear
//   alloc_valid_i/_pc_i     allocation request; alloc_ready_o = accepted
//   upd_valid_i/_addr_i/_taken_i/_target_i  resolved branch; upd_ready_o
//   wr_en_o, wr_kind_o, wr_addr_o, wr_pc_o, wr_target_o, wr_taken_o
//                           registered table write (one cycle per grant)
//   busy_o                  clear in progress
//   flush_done_o            pulses with the last clear write
module bpu_write_arbiter
  import bpu_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 64,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned UPD_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         stall_i,
  input  logic                         flush_req_i,
  input  logic                         alloc_valid_i,
  input  logic [XLEN-1:0]              alloc_pc_i,
  output logic                         alloc_ready_o,
  input  logic                         upd_valid_i,
  input  logic [$clog2(ENTRY_NUM)-1:0] upd_addr_i,
  input  logic                         upd_taken_i,
  input  logic [XLEN-1:0]              upd_target_i,
  output logic                         upd_ready_o,
  output logic                         wr_en_o,
  output logic [1:0]                   wr_kind_o,
  output logic [$clog2(ENTRY_NUM)-1:0] wr_addr_o,
  output logic [XLEN-1:0]              wr_pc_o,
  output logic [XLEN-1:0]              wr_target_o,
  output logic                         wr_taken_o,
  output logic                         busy_o,
  output logic                         flush_done_o
);

  localparam int unsigned TW = $clog2(ENTRY_NUM);
  localparam int unsigned FW = TW + 1 + XLEN;
  localparam logic [TW-1:0] LAST_IDX = TW'(ENTRY_NUM - 1);

  arb_state_e       state_q, state_d;
  logic [TW-1:0]    alloc_ptr_q, alloc_ptr_d;
  logic [TW-1:0]    clr_ptr_q, clr_ptr_d;

  logic             wr_en_q, wr_en_d;
  wr_kind_e         wr_kind_q, wr_kind_d;
  logic [TW-1:0]    wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]  wr_pc_q, wr_pc_d;
  logic [XLEN-1:0]  wr_target_q, wr_target_d;
  logic             wr_taken_q, wr_taken_d;
  logic             flush_done_q, flush_done_d;

  logic             grant_alloc, grant_upd, grant_clr;
  logic             fifo_full, fifo_empty, fifo_push;
  logic [FW-1:0]    fifo_head;
  logic [TW-1:0]    head_addr;
  logic             head_taken;
  logic [XLEN-1:0]  head_target;

  assign alloc_ready_o = (state_q == ST_IDLE) & ~stall_i & ~fifo_full;
  assign upd_ready_o   = (state_q == ST_IDLE) & ~fifo_full;
  // A flush drops any same-cycle update even though upd_ready_o may be high.
  assign fifo_push     = upd_valid_i & upd_ready_o & ~flush_req_i;

  bpu_upd_fifo #(
    .DEPTH (UPD_DEPTH),
    .WIDTH (FW)
  ) u_upd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_req_i),
    .push_i  (fifo_push),
    .data_i  ({upd_addr_i, upd_taken_i, upd_target_i}),
    .pop_i   (grant_upd),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_addr, head_taken, head_target} = fifo_head;

  always_comb begin
    state_d      = state_q;
    alloc_ptr_d  = alloc_ptr_q;
    clr_ptr_d    = clr_ptr_q;
    grant_alloc  = 1'b0;
    grant_upd    = 1'b0;
    grant_clr    = 1'b0;
    wr_kind_d    = WR_ALLOC;
    wr_addr_d    = '0;
    wr_pc_d      = '0;
    wr_target_d  = '0;
    wr_taken_d   = 1'b0;
    flush_done_d = 1'b0;

    if (flush_req_i) begin
      state_d     = ST_CLEAR;
      clr_ptr_d   = '0;
      alloc_ptr_d = '0;
    end else if (!stall_i) begin
      case (state_q)
        ST_IDLE: begin
          // A full FIFO blocks execute, so drain it ahead of decode.
          if (fifo_full)          grant_upd   = 1'b1;
          else if (alloc_valid_i) grant_alloc = 1'b1;
          else if (!fifo_empty)   grant_upd   = 1'b1;
        end
        ST_CLEAR: begin
          grant_clr = 1'b1;
          clr_ptr_d = clr_ptr_q + 1'b1;
          if (clr_ptr_q == LAST_IDX) begin
            state_d      = ST_IDLE;
            flush_done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (grant_alloc) begin
      alloc_ptr_d = alloc_ptr_q + 1'b1;
      wr_kind_d   = WR_ALLOC;
      wr_addr_d   = alloc_ptr_q;
      wr_pc_d     = alloc_pc_i;
    end
    if (grant_upd) begin
      wr_kind_d   = WR_UPDATE;
      wr_addr_d   = head_addr;
      wr_target_d = head_target;
      wr_taken_d  = head_taken;
    end
    if (grant_clr) begin
      wr_kind_d = WR_CLEAR;
      wr_addr_d = clr_ptr_q;
    end
    wr_en_d = grant_alloc | grant_upd | grant_clr;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alloc_ptr_q  <= '0;
      clr_ptr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_kind_q    <= WR_ALLOC;
      wr_addr_q    <= '0;
      wr_pc_q      <= '0;
      wr_target_q  <= '0;
      wr_taken_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      alloc_ptr_q  <= alloc_ptr_d;
      clr_ptr_q    <= clr_ptr_d;
      wr_en_q      <= wr_en_d;
      wr_kind_q    <= wr_kind_d;
      wr_addr_q    <= wr_addr_d;
      wr_pc_q      <= wr_pc_d;
      wr_target_q  <= wr_target_d;
      wr_taken_q   <= wr_taken_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_kind_o    = wr_kind_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_pc_o      = wr_pc_q;
  assign wr_target_o  = wr_target_q;
  assign wr_taken_o   = wr_taken_q;
  assign flush_done_o = flush_done_q;
  assign busy_o       = (state_q == ST_CLEAR);

endmodule : bpu_write_arbiter

// File: tb/tb_bpu_write_arbiter.sv
module tb_bpu_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush_req;
  logic        alloc_valid;
  logic [31:0] alloc_pc;
  logic        alloc_ready;
  logic        upd_valid;
  logic [5:0]  upd_addr;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_ready;
  logic        wr_en;
  logic [1:0]  wr_kind;
  logic [5:0]  wr_addr;
  logic [31:0] wr_pc;
  logic [31:0] wr_target;
  logic        wr_taken;
  logic        busy;
  logic        flush_done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  bpu_write_arbiter #(
    .ENTRY_NUM (64),
    .XLEN      (32),
    .UPD_DEPTH (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .flush_req_i   (flush_req),
    .alloc_valid_i (alloc_valid),
    .alloc_pc_i    (alloc_pc),
    .alloc_ready_o (alloc_ready),
    .upd_valid_i   (upd_valid),
    .upd_addr_i    (upd_addr),
    .upd_taken_i   (upd_taken),
    .upd_target_i  (upd_target),
    .upd_ready_o   (upd_ready),
    .wr_en_o       (wr_en),
    .wr_kind_o     (wr_kind),
    .wr_addr_o     (wr_addr),
    .wr_pc_o       (wr_pc),
    .wr_target_o   (wr_target),
    .wr_taken_o    (wr_taken),
    .busy_o        (busy),
    .flush_done_o  (flush_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [1:0] kind, input logic [5:0] addr);
    check({tag, "_en"}, wr_en, 1'b1);
    check({tag, "_kind"}, wr_kind, kind);
    check({tag, "_addr"}, wr_addr, addr);
  endtask

  int unsigned stray;

  initial begin
    rst = 1'b1; stall = 1'b0; flush_req = 1'b0;
    alloc_valid = 1'b0; alloc_pc = '0;
    upd_valid = 1'b0; upd_addr = '0; upd_taken = 1'b0; upd_target = '0;
    #3;
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", flush_done, 1'b0);
    check("rst_alloc_ready", alloc_ready, 1'b1);
    check("rst_upd_ready", upd_ready, 1'b1);
    check("rst_kind_addr", {wr_kind, wr_addr}, 8'h00);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Alloc only: addrs 0,1,2 one cycle after each grant
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1;
      alloc_pc = 32'h100 + 32'(4 * i);
      check("alloc_ready", alloc_ready, 1'b1);
      tick();
      check_wr("alloc", 2'b00, 6'(i));
      check("alloc_pc", wr_pc, 32'h100 + 32'(4 * i));
    end
    alloc_valid = 1'b0;
    tick();
    check("alloc_idle", wr_en, 1'b0);

    // Simultaneous alloc and update: ALLOC first, UPDATE next cycle
    alloc_valid = 1'b1; alloc_pc = 32'h200;
    upd_valid = 1'b1; upd_addr = 6'd5; upd_taken = 1'b1; upd_target = 32'h300;
    tick();
    alloc_valid = 1'b0; upd_valid = 1'b0;
    check_wr("sim_alloc", 2'b00, 6'd3);
    check("sim_alloc_pc", wr_pc, 32'h200);
    tick();
    check_wr("sim_upd", 2'b01, 6'd5);
    check("sim_upd_tgt", wr_target, 32'h300);
    check("sim_upd_taken", wr_taken, 1'b1);
    tick();
    check("sim_idle", wr_en, 1'b0);

    // FIFO full during stall, then drain
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1; upd_addr = 6'(10 + i);
      upd_taken = 1'(i % 2); upd_target = 32'h1000 + 32'(i);
      check("full_push_ready", upd_ready, 1'b1);
      tick();
      check("stall_no_wr", wr_en, 1'b0);
    end
    upd_valid = 1'b0;
    alloc_valid = 1'b1; alloc_pc = 32'h400;
    check("full_upd_ready", upd_ready, 1'b0);
    check("full_alloc_ready", alloc_ready, 1'b0);
    stall = 1'b0;
    check("full_alloc_ready_nostall", alloc_ready, 1'b0);
    tick();
    check_wr("drain0", 2'b01, 6'd10);
    check("drain0_tgt", wr_target, 32'h1000);
    check("drain0_taken", wr_taken, 1'b0);
    check("notfull_alloc_ready", alloc_ready, 1'b1);
    tick();
    alloc_valid = 1'b0;
    check_wr("drain_alloc", 2'b00, 6'd4);
    check("drain_alloc_pc", wr_pc, 32'h400);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_wr("drain", 2'b01, 6'(10 + i));
      check("drain_tgt", wr_target, 32'h1000 + 32'(i));
      check("drain_taken", wr_taken, 64'(i % 2));
    end
    tick();
    check("drain_idle", wr_en, 1'b0);

    // Reset pulse then 65 allocs: 65th wraps to addr 0
    rst = 1'b1;
    #1;
    check("rst2_wr_en", wr_en, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 65; i++) begin
      alloc_valid = 1'b1;
      alloc_pc = 32'h2000 + 32'(4 * i);
      tick();
      check("wrap_addr", wr_addr, 64'(i % 64));
    end
    alloc_valid = 1'b0;
    check("wrap_pc", wr_pc, 32'h2100);
    check("wrap_en", wr_en, 1'b1);

    // Flush with 2 queued updates
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      upd_valid = 1'b1; upd_addr = 6'(7 + i); upd_taken = 1'b1; upd_target = 32'hdead0;
      tick();
    end
    upd_valid = 1'b0;
    stall = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("flush_cycle_no_wr", wr_en, 1'b0);
    check("flush_busy", busy, 1'b1);
    check("clear_upd_ready", upd_ready, 1'b0);
    check("clear_alloc_ready", alloc_ready, 1'b0);
    for (int k = 0; k < 64; k++) begin
      tick();
      check_wr("clear", 2'b10, 6'(k));
      check("clear_pc", wr_pc, 32'h0);
      check("clear_done", flush_done, 64'(k == 63));
      check("clear_busy", busy, 64'(k != 63));
    end
    check("post_clear_alloc_ready", alloc_ready, 1'b1);
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wr_en || flush_done) stray++;
    end
    check("flushed_upd_never_written", stray, 0);
    alloc_valid = 1'b1; alloc_pc = 32'h500;
    tick();
    alloc_valid = 1'b0;
    check_wr("post_flush_alloc", 2'b00, 6'd0);

    // Stall mid-clear, then reset mid-clear
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("clr2_addr", wr_addr, 64'(k));
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("clr_stall_no_wr", wr_en, 1'b0);
      check("clr_stall_busy", busy, 1'b1);
    end
    stall = 1'b0;
    for (int k = 10; k < 20; k++) begin
      tick();
      check_wr("clr_resume", 2'b10, 6'(k));
    end
    rst = 1'b1;
    #1;
    check("midclr_rst_wr_en", wr_en, 1'b0);
    check("midclr_rst_busy", busy, 1'b0);
    check("midclr_rst_done", flush_done, 1'b0);
    check("midclr_rst_alloc_ready", alloc_ready, 1'b1);
    tick();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (wr_en || flush_done || busy) stray++;
    end
    check("no_auto_clear", stray, 0);
    alloc_valid = 1'b1; alloc_pc = 32'h600;
    tick();
    alloc_valid = 1'b0;
    check_wr("post_rst_alloc", 2'b00, 6'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bpu_write_arbiter
